bsg_fsb_node_boot_sequencer: RTL

// - Master-side controller that brings up the FSB nodes behind murn gateways.
// - Emits switch-command packets (cmd=1) onto the FSB ring; per node: RESET_ENABLE, ENABLE, hold, RESET_DISABLE.
// - Walks node ids 0..num_nodes_p-1 in order, skipping masked-off nodes.
// - Sits beside the ring master; its output is merged into the ring's outbound FSB stream.
//

---
 rtl/bsg_fsb_pkg.sv | 29 ++
 rtl/bsg_counter_clear_up.sv | 19 +
 rtl/bsg_fsb_node_boot_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bsg_fsb_pkg.sv
// Shared FSB packet layout and switch-command opcodes, plus the boot sequencer state encoding.
package bsg_fsb_pkg;

    typedef enum logic [6:0] {
        RNENABLE_CMD        = 7'h01,
        RNDISABLE_CMD       = 7'h02,
        RNDOWN_CMD          = 7'h03,
        RNRESET_ENABLE_CMD  = 7'h04,
        RNRESET_DISABLE_CMD = 7'h05
    } bsg_fsb_opcode_e;

    // Reference 80-bit layout (destid 4b); wider or narrower rings keep the same field order.
    typedef struct packed {
        logic [3:0]      destid;
        logic            cmd;
        bsg_fsb_opcode_e opcode;
        logic [67:0]     data;
    } bsg_fsb_pkt_s;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_RST_EN,
        BOOT_EN,
        BOOT_WAIT,
        BOOT_RST_DIS,
        BOOT_DONE
    } boot_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; holds the reset-hold count while the sequencer waits.
module bsg_counter_clear_up #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i)
            count_o <= '0;
        else if (up_i)
            count_o <= count_o + width_p'(1);
    end

endmodule

// File: rtl/bsg_fsb_node_boot_sequencer.sv
// Issues RESET_ENABLE, ENABLE, hold, RESET_DISABLE switch commands to each unmasked FSB node in id order.
module bsg_fsb_node_boot_sequencer
    import bsg_fsb_pkg::*;
#(
    parameter int width_p      = 80,
    parameter int id_width_p   = 4,
    parameter int num_nodes_p  = 4,
    parameter int reset_hold_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [num_nodes_p-1:0] node_mask_i,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int idx_w = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
    localparam int cnt_w = (reset_hold_p > 1) ? $clog2(reset_hold_p) : 1;
    localparam int op_w  = $bits(bsg_fsb_opcode_e);

    typedef logic [idx_w-1:0] idx_t;

    boot_state_e            state_r, state_n;
    idx_t                   index_r, index_n, first_idx, next_idx;
    logic [num_nodes_p-1:0] mask_r, mask_n;
    logic                   empty_r, empty_n;
    logic                   v_r, busy_r, done_r;
    bsg_fsb_opcode_e        opcode_r, opcode_n;
    logic                   next_found, fire, clear_hold, up_hold;
    logic [cnt_w-1:0]       hold_cnt;

    bsg_counter_clear_up #(.width_p(cnt_w)) hold_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_hold),
        .up_i    (up_hold),
        .count_o (hold_cnt)
    );

    // Lowest set bit of the incoming mask, and lowest set latched bit above the current index.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = num_nodes_p - 1; i >= 0; i--) begin
            if (node_mask_i[i])
                first_idx = idx_t'(i);
            if (mask_r[i] && (i > int'(index_r))) begin
                next_idx   = idx_t'(i);
                next_found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_n    = state_r;
        index_n    = index_r;
        mask_n     = mask_r;
        empty_n    = 1'b0;
        clear_hold = 1'b0;
        up_hold    = 1'b0;
        fire       = v_r & ready_i;
        case (state_r)
            BOOT_IDLE, BOOT_DONE: begin
                if (empty_r) begin
                    state_n = BOOT_DONE;
                end else if (start_i) begin
                    mask_n = node_mask_i;
                    if (|node_mask_i) begin
                        index_n = first_idx;
                        state_n = BOOT_RST_EN;
                    end else begin
                        // Empty mask: one quiet cycle with done cleared, then DONE.
                        state_n = BOOT_IDLE;
                        empty_n = 1'b1;
                    end
                end
            end
            BOOT_RST_EN: if (fire) state_n = BOOT_EN;
            BOOT_EN: begin
                if (fire) begin
                    if (reset_hold_p > 0) begin
                        state_n    = BOOT_WAIT;
                        clear_hold = 1'b1;
                    end else begin
                        state_n = BOOT_RST_DIS;
                    end
                end
            end
            BOOT_WAIT: begin
                up_hold = 1'b1;
                if (hold_cnt == cnt_w'(reset_hold_p - 1))
                    state_n = BOOT_RST_DIS;
            end
            BOOT_RST_DIS: begin
                if (fire) begin
                    if (next_found) begin
                        index_n = next_idx;
                        state_n = BOOT_RST_EN;
                    end else begin
                        state_n = BOOT_DONE;
                    end
                end
            end
            default: state_n = BOOT_IDLE;
        endcase

        case (state_n)
            BOOT_EN:      opcode_n = RNENABLE_CMD;
            BOOT_RST_DIS: opcode_n = RNRESET_DISABLE_CMD;
            default:      opcode_n = RNRESET_ENABLE_CMD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= BOOT_IDLE;
            index_r  <= '0;
            mask_r   <= '0;
            empty_r  <= 1'b0;
            v_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            opcode_r <= RNRESET_ENABLE_CMD;
        end else begin
            state_r  <= state_n;
            index_r  <= index_n;
            mask_r   <= mask_n;
            empty_r  <= empty_n;
            v_r      <= (state_n == BOOT_RST_EN) || (state_n == BOOT_EN) || (state_n == BOOT_RST_DIS);
            busy_r   <= (state_n != BOOT_IDLE) && (state_n != BOOT_DONE);
            done_r   <= (state_n == BOOT_DONE);
            opcode_r <= opcode_n;
        end
    end

    always_comb begin
        data_o = '0;
        data_o[width_p-1 -: id_width_p]         = id_width_p'(index_r);
        data_o[width_p-id_width_p-1]            = 1'b1;
        data_o[width_p-id_width_p-2 -: op_w]    = opcode_r;
    end

    assign v_o    = v_r;
    assign busy_o = busy_r;
    assign done_o = done_r;

endmodule
